// File: rtl/obi_err_sbr_if.sv
// OBI request/response channel carrying only the signals an always-erroring subordinate needs.
// Revision: 1.0
`default_nettype none

interface obi_err_sbr_if #(
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned DataWidth = 32
) ();
  logic                 req;
  logic                 gnt;
  logic [IdWidth-1:0]   aid;
  logic                 rvalid;
  logic                 rready;
  logic [IdWidth-1:0]   rid;
  logic [DataWidth-1:0] rdata;
  logic                 err;

  modport master (
    output req, aid, rready,
    input  gnt, rvalid, rid, rdata, err
  );

  modport slave (
    input  req, aid, rready,
    output gnt, rvalid, rid, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/obi_err_sbr.sv
// obi_err_sbr: OBI subordinate that answers every request, in order, with err=1 after a fixed latency.
// Revision: 1.0
`default_nettype none

module obi_err_sbr #(
  parameter int unsigned          IdWidth     = 1,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumMaxTrans = 2,
  parameter int unsigned          RspLatency  = 1,
  parameter logic [DataWidth-1:0] RspData     = DataWidth'(32'hBADCAB1E),
  parameter int unsigned          CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obi_err_sbr_if.slave        obi,
  output logic                busy_o,
  output logic [CntWidth-1:0] rsp_cnt_o
);

  localparam int unsigned PtrW  = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW  = $clog2(NumMaxTrans + 1);
  localparam int unsigned WaitW = $clog2(RspLatency + 1);

  localparam logic [PtrW-1:0]  PtrMax   = PtrW'(NumMaxTrans - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(NumMaxTrans);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(RspLatency - 1);

  logic [IdWidth-1:0]  ids_q [NumMaxTrans];
  logic [IdWidth-1:0]  ids_d [NumMaxTrans];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CntWidth-1:0] rsp_cnt_q, rsp_cnt_d;

  logic empty, full, push, pop, rvalid;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + PtrW'(1);
  endfunction

  // Grant looks only at registered occupancy, so rready never reaches gnt.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign push    = obi.req & ~full;
  assign rvalid  = ~empty & (wait_cnt_q == '0);
  assign pop     = rvalid & obi.rready;

  assign obi.gnt    = push;
  assign obi.rvalid = rvalid;
  assign obi.err    = rvalid;
  assign obi.rid    = rvalid ? ids_q[rd_ptr_q] : '0;
  assign obi.rdata  = RspData;
  assign busy_o     = ~empty;
  assign rsp_cnt_o  = rsp_cnt_q;

  always_comb begin
    ids_d      = ids_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wait_cnt_d = wait_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;

    if (push) begin
      ids_d[wr_ptr_q] = obi.aid;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (rsp_cnt_q != '1) rsp_cnt_d = rsp_cnt_q + CntWidth'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Restart the latency whenever a new entry becomes head.
    if ((push && empty) || (pop && (count_d != '0))) begin
      wait_cnt_d = WaitLoad;
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - WaitW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumMaxTrans); i++) ids_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      rsp_cnt_q  <= '0;
    end else begin
      ids_q      <= ids_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_err_sbr.sv
// tb_obi_err_sbr: drives two obi_err_sbr configurations with shared stimulus against a queue/timestamp model.
// Revision: 1.0
`default_nettype none

module tb_obi_err_sbr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obi_err_sbr_if #(.IdWidth(2), .DataWidth(32)) a_if ();
  obi_err_sbr_if #(.IdWidth(3), .DataWidth(32)) b_if ();

  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  // Instance A: default depth/latency/counter; instance B: deeper, slower, tiny counter.
  obi_err_sbr #(.IdWidth(2)) u_dut_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .obi       (a_if.slave),
    .busy_o    (busy_a),
    .rsp_cnt_o (cnt_a)
  );

  obi_err_sbr #(.IdWidth(3), .NumMaxTrans(3), .RspLatency(3), .CntWidth(2)) u_dut_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .obi       (b_if.slave),
    .busy_o    (busy_b),
    .rsp_cnt_o (cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int       depth  [2] = '{2, 3};
  int       lat    [2] = '{1, 3};
  int       cmax   [2] = '{65535, 3};
  logic [3:0] idmask [2] = '{4'h3, 4'h7};

  logic [3:0] mq [2][$];
  int         head_rdy [2];
  int         mcnt [2];

  logic       cur_req, cur_rready;
  logic [3:0] cur_aid;

  logic        o_gnt [2], o_rv [2], o_err [2], o_busy [2];
  logic [3:0]  o_rid [2];
  logic [31:0] o_rdata [2], o_cnt [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    o_gnt[0] = a_if.gnt;    o_gnt[1] = b_if.gnt;
    o_rv[0]  = a_if.rvalid; o_rv[1]  = b_if.rvalid;
    o_err[0] = a_if.err;    o_err[1] = b_if.err;
    o_rid[0] = {2'b00, a_if.rid};
    o_rid[1] = {1'b0, b_if.rid};
    o_rdata[0] = a_if.rdata; o_rdata[1] = b_if.rdata;
    o_busy[0] = busy_a;     o_busy[1] = busy_b;
    o_cnt[0] = {16'h0, cnt_a};
    o_cnt[1] = {30'h0, cnt_b};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      head_rdy[i] = 0;
      mcnt[i]     = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    sample();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_rvalid%0d", tag, i), {31'h0, o_rv[i]}, 32'd0);
      check_eq($sformatf("%s_err%0d", tag, i), {31'h0, o_err[i]}, 32'd0);
      check_eq($sformatf("%s_rid%0d", tag, i), {28'h0, o_rid[i]}, 32'd0);
      check_eq($sformatf("%s_busy%0d", tag, i), {31'h0, o_busy[i]}, 32'd0);
      check_eq($sformatf("%s_cnt%0d", tag, i), o_cnt[i], 32'd0);
    end
  endtask

  // Compare against the model for the current cycle, then advance the model.
  task automatic model_step();
    sample();
    for (int i = 0; i < 2; i++) begin
      int         sz;
      bit         e_gnt, e_rv, popped;
      logic [3:0] e_rid;
      sz     = mq[i].size();
      e_gnt  = cur_req && (sz < depth[i]);
      e_rv   = (sz > 0) && (cyc >= head_rdy[i]);
      e_rid  = e_rv ? mq[i][0] : 4'h0;
      check_eq($sformatf("gnt%0d@%0d", i, cyc), {31'h0, o_gnt[i]}, {31'h0, e_gnt});
      check_eq($sformatf("rvalid%0d@%0d", i, cyc), {31'h0, o_rv[i]}, {31'h0, e_rv});
      check_eq($sformatf("err%0d@%0d", i, cyc), {31'h0, o_err[i]}, {31'h0, e_rv});
      check_eq($sformatf("rid%0d@%0d", i, cyc), {28'h0, o_rid[i]}, {28'h0, e_rid});
      check_eq($sformatf("busy%0d@%0d", i, cyc), {31'h0, o_busy[i]}, {31'h0, (sz > 0)});
      check_eq($sformatf("cnt%0d@%0d", i, cyc), o_cnt[i], mcnt[i]);
      check_eq($sformatf("rdata%0d@%0d", i, cyc), o_rdata[i], 32'hBADCAB1E);

      popped = e_rv && cur_rready;
      if (popped) begin
        void'(mq[i].pop_front());
        if (mcnt[i] < cmax[i]) mcnt[i]++;
      end
      if (e_gnt) mq[i].push_back(cur_aid & idmask[i]);
      if ((popped || sz == 0) && mq[i].size() > 0) head_rdy[i] = cyc + lat[i];
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] aid, input logic rready);
    cur_req    = req;
    cur_aid    = aid;
    cur_rready = rready;
    a_if.req    = req;
    a_if.aid    = aid[1:0];
    a_if.rready = rready;
    b_if.req    = req;
    b_if.aid    = aid[2:0];
    b_if.rready = rready;
  endtask

  task automatic cycle(input logic req, input logic [3:0] aid, input logic rready);
    @(posedge clk);
    #1;
    cyc++;
    drive(req, aid, rready);
    @(negedge clk);
    model_step();
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #1;
    drive(1'b0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read
    cycle(1'b1, 4'h1, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    check_eq("single_cnt_a", {16'h0, cnt_a}, 32'd1);
    check_eq("single_busy_a", {31'h0, busy_a}, 32'd0);
    repeat (4) cycle(1'b0, 4'h0, 1'b1);

    // Fill to full under rready=0, then release
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b1, 4'h1, 1'b0);
    repeat (3) cycle(1'b1, 4'h2, 1'b0);
    check_eq("full_gnt_a", {31'h0, a_if.gnt}, 32'd0);
    cycle(1'b1, 4'h2, 1'b1);
    cycle(1'b1, 4'h2, 1'b0);
    repeat (12) cycle(1'b0, 4'h0, 1'b1);

    // Backpressure: response held for several cycles
    cycle(1'b1, 4'h3, 1'b0);
    repeat (6) cycle(1'b0, 4'h0, 1'b0);
    repeat (8) cycle(1'b0, 4'h0, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 7));
    end
    repeat (12) cycle(1'b0, 4'h0, 1'b1);

    // Reset with responses pending
    cycle(1'b1, 4'h1, 1'b0);
    cycle(1'b1, 4'h2, 1'b0);
    repeat (4) cycle(1'b0, 4'h0, 1'b0);
    check_eq("pre_rst_rvalid_a", {31'h0, a_if.rvalid}, 32'd1);
    check_eq("pre_rst_rvalid_b", {31'h0, b_if.rvalid}, 32'd1);
    async_reset("rst_mid");
    cycle(1'b1, 4'h3, 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
